ram_sp_stream_reader: RTL

- Read sequencer placed directly downstream of a single-port RAM wrapper. Shares the wrapper's AddrWidth, DataWidth and Pipelined parameters.
- On a start command it issues a burst of consecutive RAM reads and tracks RAM read latency. It buffers returned words and presents them as a valid/ready stream with a last marker.
- Sustains one word per cycle when the consumer never stalls. Never loses or duplicates a word under backpressure.

---
 rtl/ram_sp_stream_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ram_sp_stream_reader.sv
// Burst read sequencer for a single-port RAM: issues consecutive reads under a
// credit limit, tracks read latency, and buffers returned words into a valid/ready stream.
module ram_sp_stream_reader #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 32,
    parameter bit          Pipelined = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth:0]   len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ram_rd_en_o,
    output logic                 ram_wr_en_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    input  logic [DataWidth-1:0] ram_data_i,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
    input  logic                 out_ready_i
);
    localparam int unsigned L  = Pipelined ? 2 : 1;
    localparam int unsigned D  = L + 2;
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned PW = $clog2(D);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic                 done_q, done_d;
    logic [AddrWidth:0]   len_q, issue_cnt_q;
    logic [AddrWidth-1:0] next_addr_q, ram_addr_q;
    logic                 rd_en_q, rd_last_q;
    logic [L-1:0]         vld_pipe_q, last_pipe_q;
    logic [DataWidth-1:0] buf_data_q [D];
    logic [D-1:0]         buf_last_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, outst_q;
    logic                 issue, start_cap, push, pop, last_issue, credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign ram_rd_en_o = rd_en_q;
    assign ram_wr_en_o = 1'b0;
    assign ram_addr_o  = ram_addr_q;

    assign push        = vld_pipe_q[L-1];
    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = buf_data_q[rd_ptr_q];
    assign out_last_o  = out_valid_o && buf_last_q[rd_ptr_q];
    assign last_issue  = (issue_cnt_q == len_q - (AddrWidth + 1)'(1));
    // outst_q counts words issued but not yet consumed; a word leaving this
    // cycle frees its slot so a full pipe keeps streaming at one word per cycle.
    assign credit_ok   = (outst_q != CW'(D)) || pop;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        start_cap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        start_cap = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (issue_cnt_q != len_q && credit_ok) begin
                    issue = 1'b1;
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            next_addr_q <= '0;
            ram_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            rd_last_q   <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            rd_en_q   <= issue;
            rd_last_q <= issue && last_issue;
            if (start_cap) begin
                len_q       <= len_i;
                issue_cnt_q <= '0;
                next_addr_q <= base_addr_i;
            end
            if (issue) begin
                ram_addr_q  <= next_addr_q;
                next_addr_q <= next_addr_q + AddrWidth'(1);
                issue_cnt_q <= issue_cnt_q + (AddrWidth + 1)'(1);
            end
            // Flags ride alongside the RAM read latency; the exit stage marks valid ram_data_i.
            vld_pipe_q[0]  <= rd_en_q;
            last_pipe_q[0] <= rd_last_q;
            for (int i = 1; i < L; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            unique case ({issue, pop})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= ram_data_i;
            buf_last_q[wr_ptr_q] <= last_pipe_q[L-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count_q == CW'(D))));

endmodule
